// File: rtl/snd_pkg.sv
// Shared types and default widths for the sound voice blocks.
//   wave_mode_t : waveform selector (SINE, TRI, SQUARE, SAW)
//   DEF_*       : default widths used by the oscillator, its ROM and its interface
package snd_pkg;

    typedef enum logic [1:0] {
        SINE   = 2'd0,
        TRI    = 2'd1,
        SQUARE = 2'd2,
        SAW    = 2'd3
    } wave_mode_t;

    localparam int DEF_PHASE_W = 16;
    localparam int DEF_LUT_AW  = 6;
    localparam int DEF_OUT_W   = 8;
    localparam int DEF_AMP_W   = 4;

endpackage

// File: rtl/wave_osc_if.sv
// Control/sample bundle of one oscillator voice.
//   master : prescaler/controller side (drives tick, enable, configuration)
//   slave  : oscillator side (returns cfg_pending and the half-wave samples)
// Signals:
//   tick, enable, cfg_load, phase_inc, mode, amp  -> oscillator
//   cfg_pending, pos_out, neg_out, sample_valid, cycle_start <- oscillator
interface wave_osc_if
    import snd_pkg::*;
#(
    parameter int PHASE_W = DEF_PHASE_W,
    parameter int OUT_W   = DEF_OUT_W,
    parameter int AMP_W   = DEF_AMP_W
) ();

    logic               tick;
    logic               enable;
    logic               cfg_load;
    logic [PHASE_W-1:0] phase_inc;
    wave_mode_t         mode;
    logic [AMP_W-1:0]   amp;
    logic               cfg_pending;
    logic [OUT_W-1:0]   pos_out;
    logic [OUT_W-1:0]   neg_out;
    logic               sample_valid;
    logic               cycle_start;

    modport master (
        output tick, enable, cfg_load, phase_inc, mode, amp,
        input  cfg_pending, pos_out, neg_out, sample_valid, cycle_start
    );

    modport slave (
        input  tick, enable, cfg_load, phase_inc, mode, amp,
        output cfg_pending, pos_out, neg_out, sample_valid, cycle_start
    );

endinterface

// File: rtl/sine_quarter_lut.sv
// Quarter-wave sine ROM with a registered read.
//   clk    : read clock
//   addr_i : LUT_AW+1 bit address, 0..N; address N returns full scale
//   data_o : round((2**OUT_W-1) * sin(pi/2 * addr/N)), one cycle after addr_i
module sine_quarter_lut #(
    parameter int LUT_AW = 6,
    parameter int OUT_W  = 8
) (
    input  logic              clk,
    input  logic [LUT_AW:0]   addr_i,
    output logic [OUT_W-1:0]  data_o
);

    localparam int N = 2 ** LUT_AW;

    function automatic logic [OUT_W-1:0] rom_entry(input int i);
        real full;
        real x;
        full = real'((1 << OUT_W) - 1);
        x    = full * $sin(3.14159265358979 * real'(i) / (2.0 * real'(N)));
        return OUT_W'($rtoi(x + 0.5));
    endfunction

    logic [OUT_W-1:0] rom [N];

    for (genvar g = 0; g < N; g++) begin : g_rom
        assign rom[g] = rom_entry(g);
    end

    // The only address with the top bit set is N itself (the 90 degree point),
    // which is not stored and reads back as full scale.
    always_ff @(posedge clk) begin
        if (addr_i[LUT_AW]) begin
            data_o <= '1;
        end else begin
            data_o <= rom[addr_i[LUT_AW-1:0]];
        end
    end

endmodule

// File: rtl/wave_osc.sv
// DDS tone oscillator, one instance per voice.
//   clk, reset_n : clock and asynchronous active-low reset
//   osc (slave)  : tick/enable/config in; cfg_pending, pos_out/neg_out half-wave
//                  magnitudes, sample_valid and cycle_start out
// A tick advances the phase accumulator; three clocks later the sample for the
// phase held at that tick appears with sample_valid. New configuration waits in
// shadow registers until the accumulator wraps (or immediately when disabled).
module wave_osc
    import snd_pkg::*;
#(
    parameter int PHASE_W = DEF_PHASE_W,
    parameter int LUT_AW  = DEF_LUT_AW,
    parameter int OUT_W   = DEF_OUT_W,
    parameter int AMP_W   = DEF_AMP_W
) (
    input  logic       clk,
    input  logic       reset_n,
    wave_osc_if.slave  osc
);

    localparam int N     = 2 ** LUT_AW;
    localparam int TOP_W = OUT_W + 2;   // quadrant + OUT_W fraction bits

    // Unity gain at amp = all ones: m * (amp+1) / 2**AMP_W. The product never
    // exceeds OUT_W+AMP_W bits, so no saturation is needed.
    function automatic logic [OUT_W-1:0] scale_mag(input logic [OUT_W-1:0] m,
                                                   input logic [AMP_W-1:0] a);
        logic [OUT_W+AMP_W-1:0] mw;
        logic [OUT_W+AMP_W-1:0] aw;
        mw = (OUT_W+AMP_W)'(m);
        aw = (OUT_W+AMP_W)'(a) + (OUT_W+AMP_W)'(1);
        return OUT_W'((mw * aw) >> AMP_W);
    endfunction

    logic [PHASE_W-1:0] phase_q, phase_d;
    logic [PHASE_W-1:0] inc_q, inc_d, sh_inc_q, sh_inc_d;
    wave_mode_t         mode_q, mode_d, sh_mode_q, sh_mode_d;
    logic [AMP_W-1:0]   amp_q, amp_d, sh_amp_q, sh_amp_d;
    logic               pend_q, pend_d;
    logic               wrapped_q, wrapped_d;
    logic [PHASE_W:0]   sum;
    logic               carry;
    logic               apply;

    always_comb begin
        sum   = {1'b0, phase_q} + {1'b0, inc_q};
        carry = osc.enable & sum[PHASE_W];
        // Disabled voices take new settings on the next clock; running voices
        // only at a wrap so the waveform changes on a cycle boundary.
        apply = pend_q & (osc.enable ? (osc.tick & carry) : 1'b1);

        phase_d   = phase_q;
        wrapped_d = wrapped_q;
        if (osc.tick) begin
            phase_d   = osc.enable ? sum[PHASE_W-1:0] : '0;
            wrapped_d = carry;
        end

        inc_d  = inc_q;
        mode_d = mode_q;
        amp_d  = amp_q;
        pend_d = pend_q;
        if (apply) begin
            inc_d  = sh_inc_q;
            mode_d = sh_mode_q;
            amp_d  = sh_amp_q;
            pend_d = 1'b0;
        end

        // A load in the same cycle as an apply: the old shadow went out above,
        // the new one stays pending.
        sh_inc_d  = sh_inc_q;
        sh_mode_d = sh_mode_q;
        sh_amp_d  = sh_amp_q;
        if (osc.cfg_load) begin
            sh_inc_d  = osc.phase_inc;
            sh_mode_d = osc.mode;
            sh_amp_d  = osc.amp;
            pend_d    = 1'b1;
        end
    end

    // ---- S1: phase snapshot at the tick ----
    logic [TOP_W-1:0] top_p1_q;
    wave_mode_t       mode_p1_q;
    logic [AMP_W-1:0] amp_p1_q;
    logic             mute_p1_q, cyc_p1_q, vld_p1_q;

    logic [1:0]        quad_p1;
    logic [LUT_AW-1:0] idx_p1;
    logic [OUT_W-1:0]  frac_p1, saw_p1, alt_p1;
    logic [LUT_AW:0]   addr_p1;

    always_comb begin
        quad_p1 = top_p1_q[TOP_W-1 -: 2];
        idx_p1  = top_p1_q[TOP_W-3 -: LUT_AW];
        frac_p1 = top_p1_q[TOP_W-3 -: OUT_W];
        saw_p1  = top_p1_q[TOP_W-2 -: OUT_W];
        // Odd quadrants run the quarter wave backwards.
        addr_p1 = quad_p1[0] ? ((LUT_AW+1)'(N) - {1'b0, idx_p1}) : {1'b0, idx_p1};
        case (mode_p1_q)
            TRI:     alt_p1 = quad_p1[0] ? ~frac_p1 : frac_p1;
            SQUARE:  alt_p1 = '1;
            SAW:     alt_p1 = saw_p1;
            default: alt_p1 = '0;
        endcase
    end

    // ---- S2: magnitude (ROM read or arithmetic waveform) ----
    logic [OUT_W-1:0] rom_p2;
    logic [OUT_W-1:0] alt_p2_q;
    logic [AMP_W-1:0] amp_p2_q;
    logic             sine_p2_q, q1_p2_q, mute_p2_q, cyc_p2_q, vld_p2_q;

    sine_quarter_lut #(
        .LUT_AW (LUT_AW),
        .OUT_W  (OUT_W)
    ) u_lut (
        .clk    (clk),
        .addr_i (addr_p1),
        .data_o (rom_p2)
    );

    always_ff @(posedge clk) begin
        top_p1_q  <= phase_q[PHASE_W-1 -: TOP_W];
        mode_p1_q <= mode_q;
        amp_p1_q  <= amp_q;
        mute_p1_q <= ~osc.enable;
        cyc_p1_q  <= wrapped_q & osc.enable;

        alt_p2_q  <= alt_p1;
        sine_p2_q <= (mode_p1_q == SINE);
        q1_p2_q   <= quad_p1[1];
        amp_p2_q  <= amp_p1_q;
        mute_p2_q <= mute_p1_q;
        cyc_p2_q  <= cyc_p1_q;
    end

    // ---- S3: gain and half-wave split ----
    logic [OUT_W-1:0] scaled_p2;
    logic [OUT_W-1:0] pos_q, pos_d, neg_q, neg_d;
    logic             valid_q, cyc_q;

    always_comb begin
        scaled_p2 = mute_p2_q ? '0 : scale_mag(sine_p2_q ? rom_p2 : alt_p2_q, amp_p2_q);
        pos_d     = pos_q;
        neg_d     = neg_q;
        if (vld_p2_q) begin
            pos_d = q1_p2_q ? '0 : scaled_p2;
            neg_d = q1_p2_q ? scaled_p2 : '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            phase_q   <= '0;
            inc_q     <= '0;
            mode_q    <= SINE;
            amp_q     <= '1;
            sh_inc_q  <= '0;
            sh_mode_q <= SINE;
            sh_amp_q  <= '0;
            pend_q    <= 1'b0;
            wrapped_q <= 1'b0;
            vld_p1_q  <= 1'b0;
            vld_p2_q  <= 1'b0;
            pos_q     <= '0;
            neg_q     <= '0;
            valid_q   <= 1'b0;
            cyc_q     <= 1'b0;
        end else begin
            phase_q   <= phase_d;
            inc_q     <= inc_d;
            mode_q    <= mode_d;
            amp_q     <= amp_d;
            sh_inc_q  <= sh_inc_d;
            sh_mode_q <= sh_mode_d;
            sh_amp_q  <= sh_amp_d;
            pend_q    <= pend_d;
            wrapped_q <= wrapped_d;
            vld_p1_q  <= osc.tick;
            vld_p2_q  <= vld_p1_q;
            pos_q     <= pos_d;
            neg_q     <= neg_d;
            valid_q   <= vld_p2_q;
            cyc_q     <= vld_p2_q & cyc_p2_q;
        end
    end

    assign osc.cfg_pending  = pend_q;
    assign osc.pos_out      = pos_q;
    assign osc.neg_out      = neg_q;
    assign osc.sample_valid = valid_q;
    assign osc.cycle_start  = cyc_q;

endmodule

// File: tb/tb_wave_osc.sv
module tb_wave_osc;
    import snd_pkg::*;

    logic clk     = 1'b0;
    logic clk_run = 1'b1;
    logic reset_n = 1'b1;

    int n_chk = 0;
    int n_err = 0;

    int cap_n = 0;
    int pos_s [600];
    int neg_s [600];
    int cyc_s [600];

    wave_osc_if osc_if ();

    wave_osc dut (
        .clk     (clk),
        .reset_n (reset_n),
        .osc     (osc_if)
    );

    always begin
        #5;
        if (clk_run) clk = ~clk;
    end

    always @(negedge clk) begin
        if (osc_if.sample_valid && cap_n < 600) begin
            pos_s[cap_n] = int'(osc_if.pos_out);
            neg_s[cap_n] = int'(osc_if.neg_out);
            cyc_s[cap_n] = int'(osc_if.cycle_start);
            cap_n++;
        end
    end

    task automatic check_val(input string tag, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
        end
    endtask

    task automatic restart(input logic [15:0] inc, input wave_mode_t md, input logic [3:0] a);
        @(posedge clk); #1;
        reset_n         = 1'b0;
        osc_if.tick     = 1'b0;
        osc_if.enable   = 1'b0;
        osc_if.cfg_load = 1'b0;
        @(posedge clk); #1;
        reset_n          = 1'b1;
        osc_if.phase_inc = inc;
        osc_if.mode      = md;
        osc_if.amp       = a;
        osc_if.cfg_load  = 1'b1;
        @(posedge clk); #1;
        osc_if.cfg_load = 1'b0;
        check_val("cfg_pending_after_load", int'(osc_if.cfg_pending), 1);
        @(posedge clk); #1;
        check_val("cfg_pending_applied_disabled", int'(osc_if.cfg_pending), 0);
        osc_if.enable = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        cap_n = 0;
    endtask

    task automatic run_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            osc_if.tick = 1'b1;
        end
        @(posedge clk); #1;
        osc_if.tick = 1'b0;
        repeat (5) @(posedge clk);
        #1;
    endtask

    initial begin
        int cnt;
        osc_if.tick      = 1'b0;
        osc_if.enable    = 1'b0;
        osc_if.cfg_load  = 1'b0;
        osc_if.phase_inc = '0;
        osc_if.mode      = SINE;
        osc_if.amp       = '1;

        // Reset state
        #2 reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_val("rst_pos_out", int'(osc_if.pos_out), 0);
        check_val("rst_neg_out", int'(osc_if.neg_out), 0);
        check_val("rst_sample_valid", int'(osc_if.sample_valid), 0);
        check_val("rst_cycle_start", int'(osc_if.cycle_start), 0);
        check_val("rst_cfg_pending", int'(osc_if.cfg_pending), 0);
        reset_n = 1'b1;

        // Sine, 256-sample period
        restart(16'h0100, SINE, 4'hF);
        run_ticks(514);
        check_val("sine_count", cap_n, 514);
        check_val("sine_s0_pos", pos_s[0], 0);
        check_val("sine_s16_pos", pos_s[16], 98);
        check_val("sine_s32_pos", pos_s[32], 180);
        check_val("sine_s64_pos", pos_s[64], 255);
        check_val("sine_s64_neg", neg_s[64], 0);
        check_val("sine_s96_pos", pos_s[96], 180);
        check_val("sine_s128_pos", pos_s[128], 0);
        check_val("sine_s160_neg", neg_s[160], 180);
        check_val("sine_s192_neg", neg_s[192], 255);
        check_val("sine_s192_pos", pos_s[192], 0);
        check_val("sine_cyc_s0", cyc_s[0], 0);
        check_val("sine_cyc_s256", cyc_s[256], 1);
        check_val("sine_cyc_s512", cyc_s[512], 1);
        cnt = 0;
        for (int i = 0; i < 514; i++) cnt += cyc_s[i];
        check_val("sine_cyc_total", cnt, 2);
        cnt = 0;
        for (int i = 0; i < 514; i++) if (pos_s[i] != 0 && neg_s[i] != 0) cnt++;
        check_val("sine_both_nonzero", cnt, 0);

        // Frequency change waits for the wrap
        restart(16'h0100, SINE, 4'hF);
        for (int c = 0; c < 400; c++) begin
            @(posedge clk); #1;
            osc_if.tick     = 1'b1;
            osc_if.cfg_load = (c == 50);
            if (c == 50) osc_if.phase_inc = 16'h0200;
            if (c == 100) check_val("chg_pending_before_wrap", int'(osc_if.cfg_pending), 1);
            if (c == 300) check_val("chg_pending_after_wrap", int'(osc_if.cfg_pending), 0);
        end
        @(posedge clk); #1;
        osc_if.tick     = 1'b0;
        osc_if.cfg_load = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check_val("chg_s64_pos", pos_s[64], 255);
        check_val("chg_cyc_s256", cyc_s[256], 1);
        check_val("chg_s288_pos", pos_s[288], 255);
        check_val("chg_s320_pos", pos_s[320], 0);
        check_val("chg_s352_neg", neg_s[352], 255);
        check_val("chg_cyc_s384", cyc_s[384], 1);
        cnt = 0;
        for (int i = 0; i < 400; i++) cnt += cyc_s[i];
        check_val("chg_cyc_total", cnt, 2);

        // Square at half gain
        restart(16'h0100, SQUARE, 4'h7);
        run_ticks(256);
        check_val("sq_s0_pos", pos_s[0], 127);
        check_val("sq_s0_neg", neg_s[0], 0);
        check_val("sq_s127_pos", pos_s[127], 127);
        check_val("sq_s127_neg", neg_s[127], 0);
        check_val("sq_s128_pos", pos_s[128], 0);
        check_val("sq_s128_neg", neg_s[128], 127);
        check_val("sq_s255_pos", pos_s[255], 0);
        check_val("sq_s255_neg", neg_s[255], 127);

        // Triangle
        restart(16'h0100, TRI, 4'hF);
        run_ticks(200);
        check_val("tri_s16_pos", pos_s[16], 64);
        check_val("tri_s64_pos", pos_s[64], 255);
        check_val("tri_s96_pos", pos_s[96], 127);
        check_val("tri_s160_neg", neg_s[160], 128);

        // Sawtooth
        restart(16'h0100, SAW, 4'hF);
        run_ticks(201);
        check_val("saw_s32_pos", pos_s[32], 64);
        check_val("saw_s200_neg", neg_s[200], 144);

        // Latency with a tick every 4 clocks
        restart(16'h0100, SINE, 4'hF);
        for (int c = 0; c < 16; c++) begin
            @(posedge clk); #1;
            osc_if.tick = (c % 4 == 0);
            @(negedge clk);
            check_val("latency_valid", int'(osc_if.sample_valid), int'(c >= 3 && (c - 3) % 4 == 0));
        end
        @(posedge clk); #1;
        osc_if.tick = 1'b0;

        // Decrementing phase
        restart(16'hFFFF, SINE, 4'hF);
        run_ticks(8);
        check_val("down_s0_pos", pos_s[0], 0);
        check_val("down_s1_neg", neg_s[1], 6);
        check_val("down_s1_pos", pos_s[1], 0);
        check_val("down_s2_neg", neg_s[2], 6);
        check_val("down_cyc_s1", cyc_s[1], 0);
        check_val("down_cyc_s2", cyc_s[2], 1);

        // Asynchronous reset with the clock stopped
        restart(16'h0100, SQUARE, 4'h7);
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            osc_if.tick = 1'b1;
        end
        @(negedge clk);
        clk_run = 1'b0;
        check_val("arst_pre_pos", int'(osc_if.pos_out), 127);
        check_val("arst_pre_valid", int'(osc_if.sample_valid), 1);
        #2 reset_n = 1'b0;
        #1;
        check_val("arst_pos_out", int'(osc_if.pos_out), 0);
        check_val("arst_neg_out", int'(osc_if.neg_out), 0);
        check_val("arst_sample_valid", int'(osc_if.sample_valid), 0);
        cap_n = 0;
        #1 reset_n = 1'b1;
        #1 clk_run = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        osc_if.tick = 1'b0;
        check_val("arst_got_samples", int'(cap_n >= 1), 1);
        check_val("arst_first_pos", pos_s[0], 0);
        check_val("arst_first_neg", neg_s[0], 0);
        check_val("arst_cfg_pending", int'(osc_if.cfg_pending), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
